// File: rtl/root_pkg.sv
// rtl/root_pkg.sv - shared types, op codes and width helpers for the root service
package root_pkg;

  localparam logic OP_SQRT = 1'b0;
  localparam logic OP_CBRT = 1'b1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  function automatic int sq_bits(input int w);
    return w / 2;
  endfunction

  function automatic int cb_bits(input int w);
    return (w + 2) / 3;
  endfunction

endpackage

// File: rtl/root_engine.sv
// rtl/root_engine.sv - bit-serial floor square/cube root datapath, one result bit per cycle
module root_engine
  import root_pkg::*;
#(
  parameter int W = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  op,
  input  logic [W-1:0]          number,
  output logic                  done,
  output logic [sq_bits(W)-1:0] root
);

  localparam int SQ = sq_bits(W);
  localparam int CB = cb_bits(W);
  localparam int IW = $clog2(SQ);
  localparam int PW = (3 * CB > W) ? 3 * CB : W;

  logic [SQ-1:0]   root_q, root_d, trial;
  logic [IW-1:0]   idx_q, idx_d;
  logic [W-1:0]    number_q, number_d;
  logic            op_q, op_d;
  logic            active_q, active_d;
  logic [2*SQ-1:0] sq_ext, sq_prod;
  logic [3*CB-1:0] cb_ext, cb_prod;
  logic            keep;

  // Products are formed at full width so the compare never sees a truncated value.
  always_comb begin
    trial   = root_q | (SQ'(1) << idx_q);
    sq_ext  = (2 * SQ)'(trial);
    sq_prod = sq_ext * sq_ext;
    cb_ext  = (3 * CB)'(trial[CB-1:0]);
    cb_prod = cb_ext * cb_ext * cb_ext;
    keep    = (op_q == OP_CBRT) ? (PW'(cb_prod) <= PW'(number_q))
                                : (PW'(sq_prod) <= PW'(number_q));
  end

  always_comb begin
    root_d   = root_q;
    idx_d    = idx_q;
    number_d = number_q;
    op_d     = op_q;
    active_d = active_q;
    if (start) begin
      root_d   = '0;
      idx_d    = (op == OP_CBRT) ? IW'(CB - 1) : IW'(SQ - 1);
      number_d = number;
      op_d     = op;
      active_d = 1'b1;
    end else if (active_q) begin
      if (keep) root_d = trial;
      if (idx_q == '0) active_d = 1'b0;
      else             idx_d = idx_q - IW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      root_q   <= '0;
      idx_q    <= '0;
      number_q <= '0;
      op_q     <= 1'b0;
      active_q <= 1'b0;
    end else begin
      root_q   <= root_d;
      idx_q    <= idx_d;
      number_q <= number_d;
      op_q     <= op_d;
      active_q <= active_d;
    end
  end

  assign done = active_q && (idx_q == '0);
  assign root = root_q;

endmodule

// File: rtl/root_scheduler.sv
// rtl/root_scheduler.sv - two-requester round-robin front end and response port for root_engine
module root_scheduler
  import root_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [W-1:0] req0_number,
  input  logic         req0_op,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [W-1:0] req1_number,
  input  logic         req1_op,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic         rsp_op,
  output logic [W-1:0] rsp_root,
  output logic         busy
);

  localparam int SQ = sq_bits(W);

  state_e        state_q, state_d;
  logic          last_q, last_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic          rsp_id_q, rsp_id_d;
  logic          rsp_op_q, rsp_op_d;
  logic          grant0, grant1, accept, accept_id, accept_op;
  logic [W-1:0]  accept_number;
  logic          eng_done;
  logic [SQ-1:0] eng_root;

  // last_q names the requester granted most recently; the other one wins a tie.
  assign grant0        = req0_valid && (!req1_valid || last_q);
  assign grant1        = req1_valid && (!req0_valid || !last_q);
  assign req0_ready    = (state_q == IDLE) && grant0;
  assign req1_ready    = (state_q == IDLE) && grant1;
  assign accept        = (req0_valid && req0_ready) || (req1_valid && req1_ready);
  assign accept_id     = req1_ready;
  assign accept_op     = accept_id ? req1_op : req0_op;
  assign accept_number = accept_id ? req1_number : req0_number;

  root_engine #(.W(W)) u_engine (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (accept),
    .op     (accept_op),
    .number (accept_number),
    .done   (eng_done),
    .root   (eng_root)
  );

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_op_d    = rsp_op_q;
    unique case (state_q)
      IDLE: if (accept) begin
        state_d  = CALC;
        last_d   = accept_id;
        rsp_id_d = accept_id;
        rsp_op_d = accept_op;
      end
      CALC: if (eng_done) begin
        state_d     = DONE;
        rsp_valid_d = 1'b1;
      end
      DONE: if (rsp_ready) begin
        state_d     = IDLE;
        rsp_valid_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      last_q      <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_op_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_op_q    <= rsp_op_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_op    = rsp_op_q;
  assign rsp_root  = W'(eng_root);
  assign busy      = (state_q != IDLE);

endmodule

// File: doc/root_scheduler.md
# root_scheduler

Shared integer square/cube-root service. Two requesters issue root jobs over valid/ready. The block arbitrates round-robin, sequences a bit-serial root engine one result bit per cycle, and returns the floor root with the requester ID over a valid/ready response port. It replaces one-shot real-valued root evaluation with a synthesizable, shareable, multi-cycle resource.

## Interface
- W, default 32, operand width; even, 8..32; only 32 is sign-off verified.
- SQ_BITS = W/2, CB_BITS = ceil(W/3) (derived localparams; 16 and 11 at W=32).
- clk  in  1  rising-edge clock; the only clock.
- rst_n  in  1  reset; synchronous, active-low.
- req0_valid, req1_valid  in  1  job offered by requester 0 / 1.
- req0_ready, req1_ready  out  1  job accepted this cycle when valid is also high.
- req0_number, req1_number  in  W  unsigned operand.
- req0_op, req1_op  in  1  0 = square root, 1 = cube root.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer takes the result.
- rsp_id  out  1  requester that issued the job.
- rsp_op  out  1  op of the job.
- rsp_root  out  W  floor root, zero-extended.
- busy  out  1  high in CALC or DONE.

## Operation
- FSM states: IDLE, CALC, DONE.
- **IDLE, arbitration:**
  - If exactly one requester is valid, it is granted.
  - If both are valid, the requester not granted last is granted.
  - Pointer after reset: requester 0 wins the first tie.
  - reqN_ready = (state == IDLE) && grantN. It is combinational from valid and the pointer, so at most one ready is high.
  - Ready is 0 in CALC and DONE.
- **Accept (valid && ready in IDLE):**
  - Latch number, op and id; update the pointer to id.
  - Set root = 0.
  - Set idx = SQ_BITS-1 for sqrt, or CB_BITS-1 for cube root.
  - Go to CALC.
- **CALC, one bit per cycle:**
  - trial = root | (1 << idx).
  - sqrt: keep the bit if trial*trial <= number.
  - cbrt: keep the bit if trial*trial*trial <= number.
  - Compute products at full width (2*SQ_BITS and 3*CB_BITS bits; 33 for cube at W=32). No truncation before the compare.
  - When idx == 0, go to DONE after this cycle's update. Otherwise decrement idx.
- **DONE:**
  - rsp_valid = 1. rsp_root, rsp_id and rsp_op stay stable while rsp_ready is 0.
  - On rsp_valid && rsp_ready, go to IDLE.
- Jobs are never dropped or reordered. There is at most one job in flight.
- Operand 0 gives root 0 for either op.
- Out-of-range op values are impossible (1-bit field).

## Timing
- Reset (rst_n sampled low at a clk edge):
  - state = IDLE, pointer = 1 (requester 0 favoured).
  - rsp_valid = 0, rsp_root = 0, rsp_id = 0, rsp_op = 0, busy = 0.
  - req ready outputs follow IDLE arbitration on the next cycle.
- Reset mid-CALC or mid-DONE aborts the job. No response is ever produced for it.
- Latency: accept edge at cycle T; CALC occupies T+1..T+N; rsp_valid is high from T+N+1.
  - N = SQ_BITS for sqrt (16), CB_BITS for cube root (11).
- With rsp_ready held high, rsp_valid lasts one cycle.
- The earliest next accept is the cycle after the response handshake. Job-to-job throughput is N+2 cycles.
- A request arriving during CALC or DONE waits; its valid must be held (standard valid/ready rule).
- Simultaneous requests: the loser keeps valid high and is granted next IDLE. No requester starves, with a worst-case wait of one job.

## Structure
- Package root_pkg holds:
  - OP_SQRT/OP_CBRT localparams
  - the state enum (IDLE/CALC/DONE)
  - functions computing SQ_BITS and CB_BITS from W
- Sub-module root_engine is the bit-serial datapath.
  - Ports: clk, rst_n, start, op, number, done, root.
  - It owns idx, root, trial and the compare.
- root_scheduler holds the arbiter, FSM, response registers and handshake logic.

## Test plan
- **Single sqrt:** req0 sqrt 144 accepted at T → rsp_valid at T+17 with root 12, id 0, op 0.
- **Max cube root:** req1 cbrt 0xFFFFFFFF → root 1625 at T+12, id 1.
- **Tie arbitration after reset:** both requesters hold valid for 4 jobs → grant order 0,1,0,1; each response id matches.
- **Response backpressure:** rsp_ready low for 5 cycles in DONE → rsp fields stable, both ready outputs 0, no accept; one cycle after the handshake a waiting request is accepted.
- **Reset mid-CALC:** rst_n low at T+5 → next cycle rsp_valid 0 and busy 0; no response appears; a new sqrt 81 then yields 9.
- **Edge values:**
  - sqrt 0 → 0; sqrt 0xFFFFFFFF → 65535; sqrt 15 → 3.
  - cbrt 7 → 1; cbrt 8 → 2; cbrt 1625³ → 1625; cbrt 1625³−1 → 1624.
